// File: rtl/count_step_monitor.sv
// Observer for an up/down counter. It infers the step direction from successive samples,
// flags wraps and reversals, keeps a saturating wrap tally and latches a sticky fault on illegal jumps.
module count_step_monitor #(
    parameter int WIDTH  = 3,
    parameter int WRAP_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  counter_in,
    output logic [1:0]        dir,
    output logic              wrap_up,
    output logic              wrap_down,
    output logic              dir_change,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              fault,
    output logic [WIDTH-1:0]  fault_val,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_UP    = 3'd1,
        S_DOWN  = 3'd2,
        S_STILL = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] DIR_IDLE  = 2'b00;
    localparam logic [1:0] DIR_UP    = 2'b01;
    localparam logic [1:0] DIR_DOWN  = 2'b10;
    localparam logic [1:0] DIR_STILL = 2'b11;

    state_t              state_q;
    logic [WIDTH-1:0]    prev_q;
    logic [1:0]          last_dir_q;  // DIR_IDLE here means no non-zero step seen yet
    logic [1:0]          dir_q;
    logic                wrap_up_q;
    logic                wrap_down_q;
    logic                dir_change_q;
    logic [WRAP_W-1:0]   wrap_cnt_q;
    logic                fault_q;
    logic [WIDTH-1:0]    fault_val_q;

    logic [WIDTH-1:0]    delta;
    logic                step_zero;
    logic                step_up;
    logic                step_dn;
    logic                at_zero;
    logic                at_max;
    logic [WRAP_W-1:0]   wrap_cnt_sat;

    // Modular difference makes max->0 a +1 step and 0->max a -1 step.
    assign delta        = counter_in - prev_q;
    assign step_zero    = (delta == '0);
    assign step_up      = (delta == WIDTH'(1));
    assign step_dn      = (delta == '1);
    assign at_zero      = (counter_in == '0);
    assign at_max       = (counter_in == '1);
    assign wrap_cnt_sat = (wrap_cnt_q == '1) ? wrap_cnt_q : wrap_cnt_q + WRAP_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            prev_q       <= '0;
            last_dir_q   <= DIR_IDLE;
            dir_q        <= DIR_IDLE;
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
            dir_change_q <= 1'b0;
            wrap_cnt_q   <= '0;
            fault_q      <= 1'b0;
            fault_val_q  <= '0;
        end else begin
            wrap_up_q    <= 1'b0;
            wrap_down_q  <= 1'b0;
            dir_change_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    prev_q  <= counter_in;
                    state_q <= S_STILL;
                    dir_q   <= DIR_STILL;
                end
                S_UP, S_DOWN, S_STILL: begin
                    if (step_zero) begin
                        state_q <= S_STILL;
                        dir_q   <= DIR_STILL;
                    end else if (step_up) begin
                        state_q      <= S_UP;
                        dir_q        <= DIR_UP;
                        prev_q       <= counter_in;
                        wrap_up_q    <= at_zero;
                        dir_change_q <= (last_dir_q == DIR_DOWN);
                        last_dir_q   <= DIR_UP;
                        if (at_zero) wrap_cnt_q <= wrap_cnt_sat;
                    end else if (step_dn) begin
                        state_q      <= S_DOWN;
                        dir_q        <= DIR_DOWN;
                        prev_q       <= counter_in;
                        wrap_down_q  <= at_max;
                        dir_change_q <= (last_dir_q == DIR_UP);
                        last_dir_q   <= DIR_DOWN;
                        if (at_max) wrap_cnt_q <= wrap_cnt_sat;
                    end else begin
                        // Illegal jump: dir keeps its last value, everything freezes until reset.
                        state_q     <= S_FAULT;
                        fault_q     <= 1'b1;
                        fault_val_q <= counter_in;
                    end
                end
                S_FAULT: begin
                    state_q <= S_FAULT;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dir        = dir_q;
    assign wrap_up    = wrap_up_q;
    assign wrap_down  = wrap_down_q;
    assign dir_change = dir_change_q;
    assign wrap_cnt   = wrap_cnt_q;
    assign fault      = fault_q;
    assign fault_val  = fault_val_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_count_step_monitor.sv
// Directed bench for count_step_monitor: a wide (WRAP_W=8) and a narrow (WRAP_W=2) instance share stimulus.
module tb_count_step_monitor;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [2:0] counter_in = 3'd0;

    logic [1:0] dir_w, dir_n;
    logic       wup_w, wup_n, wdn_w, wdn_n, dch_w, dch_n;
    logic [7:0] wcnt_w;
    logic [1:0] wcnt_n;
    logic       fault_w, fault_n;
    logic [2:0] fval_w, fval_n;
    logic [2:0] st_w, st_n;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    count_step_monitor #(.WIDTH(3), .WRAP_W(8)) u_wide (
        .clk(clk), .reset(reset), .counter_in(counter_in),
        .dir(dir_w), .wrap_up(wup_w), .wrap_down(wdn_w), .dir_change(dch_w),
        .wrap_cnt(wcnt_w), .fault(fault_w), .fault_val(fval_w), .dbg_state(st_w)
    );

    count_step_monitor #(.WIDTH(3), .WRAP_W(2)) u_narrow (
        .clk(clk), .reset(reset), .counter_in(counter_in),
        .dir(dir_n), .wrap_up(wup_n), .wrap_down(wdn_n), .dir_change(dch_n),
        .wrap_cnt(wcnt_n), .fault(fault_n), .fault_val(fval_n), .dbg_state(st_n)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Drive one sample, let it be taken on the next rising edge, then settle.
    task automatic step(input int v);
        counter_in = 3'(v);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Checks dir and the three pulses of the wide instance in one call.
    task automatic expect_out(input string tag, input int d, input int wu, input int wd, input int dc);
        check({tag, ".dir"}, dir_w, d);
        check({tag, ".wrap_up"}, wup_w, wu);
        check({tag, ".wrap_down"}, wdn_w, wd);
        check({tag, ".dir_change"}, dch_w, dc);
    endtask

    initial begin
        // Reset state
        do_reset(2);
        expect_out("rst", 0, 0, 0, 0);
        check("rst.wrap_cnt", wcnt_w, 0);
        check("rst.fault", fault_w, 0);
        check("rst.fault_val", fval_w, 0);
        check("rst.state", st_w, 0);

        // 1: full up run with a single wrap_up
        step(0);
        expect_out("t1.first", 3, 0, 0, 0);
        for (int v = 1; v <= 7; v++) begin
            step(v);
            expect_out("t1.up", 1, 0, 0, 0);
        end
        step(0);
        expect_out("t1.wrap", 1, 1, 0, 0);
        check("t1.wrap_cnt", wcnt_w, 1);
        check("t1.fault", fault_w, 0);
        step(1);
        expect_out("t1.after", 1, 0, 0, 0);

        // 2: down run through 0->7
        do_reset(1);
        step(3); expect_out("t2.s3", 3, 0, 0, 0);
        step(2); expect_out("t2.s2", 2, 0, 0, 0);
        step(1); expect_out("t2.s1", 2, 0, 0, 0);
        step(0); expect_out("t2.s0", 2, 0, 0, 0);
        step(7); expect_out("t2.s7", 2, 0, 1, 0);
        check("t2.wrap_cnt", wcnt_w, 1);
        step(6); expect_out("t2.s6", 2, 0, 0, 0);

        // 3: reversal, then still then down without reversal
        do_reset(1);
        step(4); expect_out("t3.s4", 3, 0, 0, 0);
        step(5); expect_out("t3.s5", 1, 0, 0, 0);
        step(6); expect_out("t3.s6", 1, 0, 0, 0);
        step(5); expect_out("t3.rev", 2, 0, 0, 1);
        step(5); expect_out("t3.st1", 3, 0, 0, 0);
        step(5); expect_out("t3.st2", 3, 0, 0, 0);
        step(4); expect_out("t3.s4b", 2, 0, 0, 0);

        // 4: reversal across a STILL gap, then wrap_down without reversal
        do_reset(1);
        step(1); expect_out("t4.s1", 3, 0, 0, 0);
        step(2); expect_out("t4.s2", 1, 0, 0, 0);
        step(2); expect_out("t4.g1", 3, 0, 0, 0);
        step(2); expect_out("t4.g2", 3, 0, 0, 0);
        step(1); expect_out("t4.rev", 2, 0, 0, 1);
        step(0); expect_out("t4.s0", 2, 0, 0, 0);
        step(7); expect_out("t4.s7", 2, 0, 1, 0);
        check("t4.wrap_cnt", wcnt_w, 1);

        // 7: wrap_down coinciding with dir_change after an up run
        do_reset(1);
        step(6); step(7);
        step(0); expect_out("t7.wup", 1, 1, 0, 0);
        step(7); expect_out("t7.both", 2, 0, 1, 1);
        check("t7.wrap_cnt", wcnt_w, 2);

        // 5: fault is sticky and freezes everything
        do_reset(1);
        step(6); step(7); step(0); step(1); step(2);
        expect_out("t5.pre", 1, 0, 0, 0);
        check("t5.pre_cnt", wcnt_w, 1);
        step(5);
        expect_out("t5.fault", 1, 0, 0, 0);
        check("t5.fault", fault_w, 1);
        check("t5.fault_val", fval_w, 5);
        check("t5.state", st_w, 4);
        step(6); step(7);
        step(0);
        expect_out("t5.frozen", 1, 0, 0, 0);
        check("t5.frozen_cnt", wcnt_w, 1);
        check("t5.frozen_val", fval_w, 5);
        check("t5.still_fault", fault_w, 1);
        step(7);
        expect_out("t5.frozen2", 1, 0, 0, 0);
        do_reset(1);
        check("t5.rst_fault", fault_w, 0);
        check("t5.rst_cnt", wcnt_w, 0);
        check("t5.rst_dir", dir_w, 0);
        check("t5.rst_val", fval_w, 0);

        // 6: saturation of the narrow counter, then reset mid-run
        step(0);
        for (int k = 0; k < 5; k++) begin
            for (int v = 1; v <= 7; v++) step(v);
            step(0);
            check("t6.wrap_up_n", wup_n, 1);
            check("t6.cnt_n", wcnt_n, (k + 1 > 3) ? 3 : k + 1);
            check("t6.cnt_w", wcnt_w, k + 1);
        end
        step(1); step(2); step(3);
        counter_in = 3'd4;
        do_reset(1);
        check("t6.rst_dir", dir_n, 0);
        check("t6.rst_cnt_n", wcnt_n, 0);
        check("t6.rst_cnt_w", wcnt_w, 0);
        check("t6.rst_state", st_n, 0);
        step(4);
        check("t6.reacq_dir", dir_n, 3);
        check("t6.reacq_dch", dch_n, 0);
        step(5);
        check("t6.up_dir", dir_n, 1);
        check("t6.up_dch", dch_n, 0);
        check("t6.up_cnt", wcnt_n, 0);
        step(4);
        check("t6.rev_n", dch_n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/count_step_monitor.md
Name: count_step_monitor

Overview:
- Sits directly downstream of the 3-bit up/down counter and consumes its count value every clock.
- Infers the count direction from successive samples and flags wrap-arounds (max->0 up, 0->max down) and direction reversals.
- Keeps a saturating wrap tally and latches a sticky fault on any illegal step (a jump other than +1, -1 or 0).
- Used by the system and the bench as a self-checking observer of the counter.

Parameters:
WIDTH, 3, counter width in bits; WIDTH >= 2 required.
WRAP_W, 8, width of the saturating wrap counter.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-high reset.
counter_in  input  WIDTH  count value from upstream counter, sampled every rising edge.
dir  output  2  observed state: 00 IDLE, 01 UP, 10 DOWN, 11 STILL.
wrap_up  output  1  one-cycle pulse: step max->0 observed.
wrap_down  output  1  one-cycle pulse: step 0->max observed.
dir_change  output  1  one-cycle pulse: step direction differs from last non-zero step direction.
wrap_cnt  output  WRAP_W  total wraps (up and down) since reset; saturates at all-ones.
fault  output  1  sticky: illegal step seen.
fault_val  output  WIDTH  counter_in value that caused the fault.

Behaviour:
- Clock and reset:
  - Single clock; reset is synchronous and active-high.
  - Reset is honoured at any time, including mid-count or in FAULT.
  - Reset values: state=IDLE, dir=00, prev=0, last_dir=none, all pulses 0, wrap_cnt=0, fault=0, fault_val=0.
- State machine: IDLE, UP, DOWN, STILL, FAULT. dir mirrors the state; FAULT keeps dir at its last value.
- IDLE: first edge with reset low captures counter_in into prev, moves to STILL, emits no pulses.
- Step decode, in UP/DOWN/STILL each edge: delta = (counter_in - prev) mod 2^WIDTH.
  - delta=1: go to UP. If counter_in=0, pulse wrap_up.
  - delta=2^WIDTH-1: go to DOWN. If counter_in=2^WIDTH-1, pulse wrap_down.
  - delta=0: go to STILL; no pulses; last_dir unchanged.
  - Otherwise: go to FAULT, set fault=1, fault_val=counter_in.
  - prev <= counter_in on every legal step.
- dir_change:
  - Pulses when a non-zero step's direction is opposite to last_dir and last_dir is valid.
  - A STILL gap between opposite steps still counts as a reversal.
  - last_dir updates on every non-zero step.
- wrap_cnt: increments by 1 on each wrap_up or wrap_down and saturates at 2^WRAP_W-1.
- Latency: all outputs are registered. The sample taken at edge N produces outputs valid after edge N, and pulses last exactly one cycle.
- FAULT: absorbing until reset.
  - No pulses; wrap_cnt and fault_val frozen; counter_in ignored.
  - The faulting step itself produces no wrap or dir_change pulse.
- Simultaneous events:
  - wrap_up/wrap_down and dir_change may assert in the same cycle (e.g. 0->7 after an up run).
  - wrap_up and wrap_down are never both 1.

Test Plan:
1. Reset 2 cycles, then counter_in 0,1,...,7,0 -> dir=11 after the first sample, then 01. wrap_up pulses once, in the cycle after 0 is sampled. wrap_cnt=1, fault=0.
2. counter_in 3,2,1,0,7,6 -> dir=10, wrap_down single pulse after 7 is sampled, wrap_cnt=1, no dir_change.
3. counter_in 4,5,6,5 -> exactly one dir_change pulse, after 5 is sampled the second time; dir goes 01->10. Then 5,5,4 -> dir=11 then 10, no further dir_change.
4. counter_in 1,2,2,2,1 -> dir_change pulses on the step 2->1 despite the STILL gap. Then 0,7 -> wrap_down and no dir_change.
5. counter_in 2,5 -> fault=1, fault_val=5, dir stays at prior value. Subsequent 6,7,0 -> no pulses, wrap_cnt unchanged. Assert reset 1 cycle -> fault=0, wrap_cnt=0, dir=00.
6. With WRAP_W=2, drive 5 full up cycles (0..7 repeated) -> wrap_cnt reads 1,2,3,3,3. Reset mid-run at value 4 -> outputs cleared on the next edge, and re-acquisition starts from IDLE.
